// File: rtl/dcc_antilog_decoder.sv
// Antilogarithm decoder: converts a log-domain sum {K, F} back to the linear product (1.F) * 2^K.
// The pipeline has three valid/ready stages under one global stall, with a zero bypass and saturation.
module dcc_antilog_decoder #(
    parameter int DataIN_width     = 16,
    parameter int truncation_width = 6,
    parameter int DataK_width      = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DataK_width+truncation_width+1:0]     in_L,
    input  logic                                        in_zero,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [2*DataIN_width-1:0]                   out_P,
    output logic                                        out_sat
);

    localparam int PW = 2 * DataIN_width;
    localparam int TW = truncation_width;
    localparam int KW = DataK_width + 2;
    localparam int LW = KW + TW;

    logic          advance;

    logic          s1_valid_q;
    logic [LW-1:0] s1_L_q;
    logic          s1_zero_q;

    logic          s2_valid_q;
    logic [TW:0]   s2_m_q;
    logic          s2_left_q;
    logic [KW-1:0] s2_sh_q;
    logic          s2_sat_q;
    logic          s2_zero_q;

    logic          out_valid_q;
    logic [PW-1:0] out_P_q;
    logic          out_sat_q;

    logic [KW-1:0] s2_k;
    logic [TW:0]   s2_m_d;
    logic          s2_left_d;
    logic [KW-1:0] s2_sh_d;
    logic          s2_sat_d;

    logic [PW-1:0] s3_m_ext;
    logic [PW-1:0] s3_shifted;
    logic [PW-1:0] out_P_d;
    logic          out_sat_d;

    assign advance   = out_ready | ~out_valid_q;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_P     = out_P_q;
    assign out_sat   = out_sat_q;

    // Stage 2: split K/F, choose the shift direction and amount relative to the binary point.
    always_comb begin
        s2_k      = s1_L_q[LW-1:TW];
        s2_m_d    = {1'b1, s1_L_q[TW-1:0]};
        s2_left_d = (s2_k >= KW'(TW));
        s2_sh_d   = s2_left_d ? (s2_k - KW'(TW)) : (KW'(TW) - s2_k);
        s2_sat_d  = (32'(s2_k) >= 32'(PW));
    end

    // Stage 3: the barrel shift; out-of-range left shifts only occur when saturating.
    always_comb begin
        s3_m_ext   = PW'(s2_m_q);
        s3_shifted = s2_left_q ? (s3_m_ext << s2_sh_q) : (s3_m_ext >> s2_sh_q);
        if (s2_zero_q) begin
            out_P_d   = '0;
            out_sat_d = 1'b0;
        end else if (s2_sat_q) begin
            out_P_d   = '1;
            out_sat_d = 1'b1;
        end else begin
            out_P_d   = s3_shifted;
            out_sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_L_q      <= '0;
            s1_zero_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_m_q      <= '0;
            s2_left_q   <= 1'b0;
            s2_sh_q     <= '0;
            s2_sat_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_P_q     <= '0;
            out_sat_q   <= 1'b0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s1_L_q      <= in_L;
            s1_zero_q   <= in_zero;
            s2_valid_q  <= s1_valid_q;
            s2_m_q      <= s2_m_d;
            s2_left_q   <= s2_left_d;
            s2_sh_q     <= s2_sh_d;
            s2_sat_q    <= s2_sat_d;
            s2_zero_q   <= s1_zero_q;
            out_valid_q <= s2_valid_q;
            out_P_q     <= out_P_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_dcc_antilog_decoder.sv
// Self-checking bench for dcc_antilog_decoder: an arithmetic reference model with an in-order queue,
// directed extremes, streaming, random backpressure and reset mid-stream.
module tb_dcc_antilog_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_L;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_P;
    logic        out_sat;

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    int cycle = 0;

    logic [32:0] expq[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_P = '0;
    logic        prev_sat = 1'b0;
    logic        track = 1'b0;
    logic        seen_out = 1'b0;
    int          first_out = 0;
    int          last_out = 0;

    dcc_antilog_decoder #(
        .DataIN_width(16),
        .truncation_width(6),
        .DataK_width(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_L(in_L),
        .in_zero(in_zero),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_P(out_P),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Reference: value = ({1,F} * 2^K) / 2^6 truncated, all ones when K >= 32, zero when bypassed.
    function automatic logic [32:0] model(input logic [5:0] k, input logic [5:0] f, input logic z);
        logic [127:0] w;
        if (z) return '0;
        if (k >= 6'd32) return {1'b1, 32'hFFFF_FFFF};
        w = {121'd0, 1'b1, f};
        w = (w << k) >> 6;
        return {1'b0, w[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (prev_stall) begin
                    check("stable_P", 64'(out_P), 64'(prev_P));
                    check("stable_sat", 64'(out_sat), 64'(prev_sat));
                end
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got P=0x%0h with nothing outstanding (t=%0t)", out_P, $time);
                end else begin
                    check("out_P", 64'(out_P), 64'(expq[0][31:0]));
                    check("out_sat", 64'(out_sat), 64'(expq[0][32]));
                    if (out_ready) begin
                        void'(expq.pop_front());
                        n_out++;
                        if (track) begin
                            if (!seen_out) first_out = cycle;
                            seen_out = 1'b1;
                            last_out = cycle;
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_P     = out_P;
            prev_sat   = out_sat;
            if (in_valid && in_ready) expq.push_back(model(in_L[11:6], in_L[5:0], in_zero));
        end
    end

    task automatic send_one(input logic [5:0] k, input logic [5:0] f, input logic z,
                            input logic [31:0] ep, input logic es);
        int          cnt;
        logic [32:0] m;
        m = model(k, f, z);
        check("model_P", 64'(m[31:0]), 64'(ep));
        check("model_sat", 64'(m[32]), 64'(es));
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_L      = {k, f};
        in_zero   = z;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1;
        while (cnt < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cnt++;
        end
        check("latency", 64'(cnt), 64'd3);
        check("dir_P", 64'(out_P), 64'(ep));
        check("dir_sat", 64'(out_sat), 64'(es));
    endtask

    initial begin
        int acc_cyc;
        int base;
        int sent;
        int guard;
        int vcount;
        logic acc;

        rst = 1'b1; in_valid = 1'b0; in_L = '0; in_zero = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_P", 64'(out_P), 64'd0);
        check("rst_sat", 64'(out_sat), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        send_one(6'd6,  6'd0,  1'b0, 32'd64,         1'b0);
        send_one(6'd3,  6'd32, 1'b0, 32'd12,         1'b0);
        send_one(6'd1,  6'd63, 1'b0, 32'd3,          1'b0);
        send_one(6'd0,  6'd63, 1'b0, 32'd1,          1'b0);
        send_one(6'd31, 6'd0,  1'b0, 32'h8000_0000,  1'b0);
        send_one(6'd32, 6'd0,  1'b0, 32'hFFFF_FFFF,  1'b1);
        send_one(6'd63, 6'd63, 1'b0, 32'hFFFF_FFFF,  1'b1);
        send_one(6'd40, 6'd5,  1'b1, 32'd0,          1'b0);
        send_one(6'd12, 6'd21, 1'b0, 32'd5440,       1'b0);

        // Streaming: 20 back-to-back beats, downstream always ready.
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = n_out;
        seen_out = 1'b0;
        track = 1'b1;
        acc_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_L     = {6'((i * 3) % 40), 6'((i * 13) % 64)};
            in_zero  = (i % 7 == 3);
            @(posedge clk); #1;
            if (i == 0) acc_cyc = cycle;
        end
        in_valid = 1'b0;
        guard = 0;
        while (n_out - base < 20 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        track = 1'b0;
        check("stream_count", 64'(n_out - base), 64'd20);
        check("stream_latency", 64'(first_out - acc_cyc + 1), 64'd3);
        check("stream_rate", 64'(last_out - first_out), 64'd19);

        // Random backpressure with random input gaps.
        base = n_out;
        sent = 0;
        guard = 0;
        while (sent < 40 && guard < 400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_L      = 12'($urandom);
            in_zero   = ($urandom_range(0, 9) == 0);
            out_ready = $urandom_range(0, 1) == 1;
            #3;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (expq.size() != 0 && guard < 400) begin
            out_ready = $urandom_range(0, 1) == 1;
            @(posedge clk); #1;
            guard++;
        end
        check("bp_sent", 64'(sent), 64'd40);
        check("bp_drained", 64'(expq.size()), 64'd0);
        check("bp_count", 64'(n_out - base), 64'd40);

        // Reset with three beats in flight while stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_L     = {6'(10 + i), 6'(i * 9)};
            in_zero  = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("inflight_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_P", 64'(out_P), 64'd0);
        check("async_rst_sat", 64'(out_sat), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("no_stale_beat", 64'(vcount), 64'd0);
        send_one(6'd8, 6'd16, 1'b0, 32'd320, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
